// File: rtl/tx_scheduler.sv
// Single-byte UART transmit scheduler: arbitrates three requesters (req[0] fixed
// priority, req[1]/req[2] round-robin), holds the byte through SEND, then enforces an idle GAP.
module tx_scheduler #(
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       script_mode,
    input  logic [2:0] req,
    input  logic [7:0] req_data_0,
    input  logic [7:0] req_data_1,
    input  logic [7:0] req_data_2,
    input  logic       tx_done,
    input  logic       clear_err,
    output logic [7:0] tx_bits,
    output logic       tx_valid,
    output logic [2:0] grant,
    output logic [2:0] done,
    output logic [1:0] cur_src,
    output logic       busy,
    output logic       timeout_err
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned GAP_W = 8;
    localparam logic [CNT_W-1:0] SEND_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [1:0]       SRC_IDLE  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] send_cnt_q, send_cnt_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]       tx_bits_q, tx_bits_d;
    logic             tx_valid_q, tx_valid_d;
    logic [2:0]       grant_q, grant_d;
    logic [2:0]       done_q, done_d;
    logic [1:0]       cur_src_q, cur_src_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    // ptr_q = 0: requester 1 preferred on a 1/2 tie, 1: requester 2 preferred
    logic             ptr_q, ptr_d;
    // Low for the first edge after reset so no grant lands on that edge
    logic             armed_q, armed_d;

    logic             win_valid;
    logic [1:0]       win_idx;
    logic [7:0]       win_data;

    // Arbitration: req[0] absolute priority, round-robin between 1 and 2
    always_comb begin
        win_valid = |req;
        win_idx   = 2'd0;
        if (req[0]) begin
            win_idx = 2'd0;
        end else if (req[1] && req[2]) begin
            win_idx = ptr_q ? 2'd2 : 2'd1;
        end else if (req[1]) begin
            win_idx = 2'd1;
        end else begin
            win_idx = 2'd2;
        end
        case (win_idx)
            2'd0:    win_data = req_data_0;
            2'd1:    win_data = req_data_1;
            default: win_data = req_data_2;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        send_cnt_d = send_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        tx_bits_d  = tx_bits_q;
        tx_valid_d = tx_valid_q;
        grant_d    = 3'b000;
        done_d     = 3'b000;
        cur_src_d  = cur_src_q;
        busy_d     = busy_q;
        ptr_d      = ptr_q;
        armed_d    = 1'b1;
        err_d      = clear_err ? 1'b0 : err_q;

        case (state_q)
            ST_IDLE: begin
                if (armed_q && !script_mode && win_valid) begin
                    state_d    = ST_SEND;
                    send_cnt_d = '0;
                    tx_bits_d  = win_data;
                    tx_valid_d = 1'b1;
                    grant_d    = 3'b001 << win_idx;
                    cur_src_d  = win_idx;
                    busy_d     = 1'b1;
                    if (win_idx == 2'd1) begin
                        ptr_d = 1'b1;
                    end else if (win_idx == 2'd2) begin
                        ptr_d = 1'b0;
                    end
                end
            end
            ST_SEND: begin
                // tx_done takes precedence over a coinciding timeout
                if (tx_done) begin
                    state_d    = ST_GAP;
                    gap_cnt_d  = '0;
                    tx_valid_d = 1'b0;
                    done_d     = 3'b001 << cur_src_q;
                end else if (send_cnt_q == SEND_LAST) begin
                    state_d    = ST_GAP;
                    gap_cnt_d  = '0;
                    tx_valid_d = 1'b0;
                    err_d      = 1'b1;
                end else if (send_cnt_q != '1) begin
                    send_cnt_d = send_cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d   = ST_IDLE;
                    cur_src_d = SRC_IDLE;
                    busy_d    = 1'b0;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                tx_valid_d = 1'b0;
                cur_src_d  = SRC_IDLE;
                busy_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            send_cnt_q <= '0;
            gap_cnt_q  <= '0;
            tx_bits_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            grant_q    <= 3'b000;
            done_q     <= 3'b000;
            cur_src_q  <= SRC_IDLE;
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
            ptr_q      <= 1'b0;
            armed_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            send_cnt_q <= send_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            tx_bits_q  <= tx_bits_d;
            tx_valid_q <= tx_valid_d;
            grant_q    <= grant_d;
            done_q     <= done_d;
            cur_src_q  <= cur_src_d;
            busy_q     <= busy_d;
            err_q      <= err_d;
            ptr_q      <= ptr_d;
            armed_q    <= armed_d;
        end
    end

    assign tx_bits     = tx_bits_q;
    assign tx_valid    = tx_valid_q;
    assign grant       = grant_q;
    assign done        = done_q;
    assign cur_src     = cur_src_q;
    assign busy        = busy_q;
    assign timeout_err = err_q;

endmodule

// File: tb/tb_tx_scheduler.sv
// Transaction-level bench for tx_scheduler: predicts winner, byte, done/timeout
// and gap length per transfer from the arbitration rules, with randomized traffic.
module tb_tx_scheduler;

    localparam int unsigned GAP = 3;
    localparam int unsigned TO  = 16;

    logic       clock = 1'b0;
    logic       reset;
    logic       script_mode;
    logic [2:0] req;
    logic [7:0] req_data_0, req_data_1, req_data_2;
    logic       tx_done;
    logic       clear_err;
    logic [7:0] tx_bits;
    logic       tx_valid;
    logic [2:0] grant;
    logic [2:0] done;
    logic [1:0] cur_src;
    logic       busy;
    logic       timeout_err;

    int n_checks = 0;
    int n_fail   = 0;
    int ptr_m;        // requester (1 or 2) favoured on the next 1/2 tie
    logic err_m;

    tx_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .script_mode(script_mode), .req(req),
        .req_data_0(req_data_0), .req_data_1(req_data_1), .req_data_2(req_data_2),
        .tx_done(tx_done), .clear_err(clear_err), .tx_bits(tx_bits),
        .tx_valid(tx_valid), .grant(grant), .done(done), .cur_src(cur_src),
        .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".grant"},    32'(grant),    32'd0);
        check({tag, ".done"},     32'(done),     32'd0);
        check({tag, ".busy"},     32'(busy),     32'd0);
        check({tag, ".tx_valid"}, 32'(tx_valid), 32'd0);
        check({tag, ".cur_src"},  32'(cur_src),  32'd3);
        check({tag, ".err"},      32'(timeout_err), 32'(err_m));
    endtask

    // Entered in an IDLE cycle; returns in the first IDLE cycle after GAP.
    // dly >= TO means tx_done is never pulsed (timeout path).
    task automatic do_xfer(input logic [2:0] r, input logic [7:0] a0, input logic [7:0] a1,
                           input logic [7:0] a2, input int dly, input bit raise_script,
                           input bit gap_noise);
        int k;
        logic [7:0] exp_b;
        logic [2:0] oh;
        bit to;
        int nsend;
        req = r; req_data_0 = a0; req_data_1 = a1; req_data_2 = a2;
        script_mode = 1'b0; clear_err = 1'b0; tx_done = 1'b0;
        if (r[0])              k = 0;
        else if (r[1] && r[2]) k = ptr_m;
        else if (r[1])         k = 1;
        else                   k = 2;
        if (k == 1) ptr_m = 2;
        else if (k == 2) ptr_m = 1;
        exp_b = (k == 0) ? a0 : ((k == 1) ? a1 : a2);
        oh = 3'b001 << k;
        step();
        check("grant",    32'(grant),    32'(oh));
        check("tx_bits",  32'(tx_bits),  32'(exp_b));
        check("tx_valid", 32'(tx_valid), 32'd1);
        check("cur_src",  32'(cur_src),  32'(k));
        check("busy",     32'(busy),     32'd1);
        if (raise_script) script_mode = 1'b1;
        to = (dly >= int'(TO));
        nsend = to ? int'(TO) - 1 : dly;
        for (int i = 0; i < nsend; i++) begin
            req_data_0 = 8'($urandom); req_data_1 = 8'($urandom); req_data_2 = 8'($urandom);
            step();
            check("send.tx_valid", 32'(tx_valid), 32'd1);
            check("send.tx_bits",  32'(tx_bits),  32'(exp_b));
            check("send.grant",    32'(grant),    32'd0);
            check("send.done",     32'(done),     32'd0);
        end
        if (!to) tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        if (to) err_m = 1'b1;
        check("exit.done",     32'(done),        to ? 32'd0 : 32'(oh));
        check("exit.tx_valid", 32'(tx_valid),    32'd0);
        check("exit.err",      32'(timeout_err), 32'(err_m));
        check("exit.busy",     32'(busy),        32'd1);
        for (int g = 0; g < int'(GAP); g++) begin
            if (gap_noise) tx_done = 1'($urandom_range(0, 1));
            step();
            if (g < int'(GAP) - 1) begin
                check("gap.busy",    32'(busy),    32'd1);
                check("gap.done",    32'(done),    32'd0);
                check("gap.cur_src", 32'(cur_src), 32'(k));
            end
        end
        tx_done = 1'b0;
        check_idle("post_gap");
    endtask

    // IDLE cycles with either no request or script_mode masking random requests
    task automatic idle_cycles(input int n, input bit script, input bit clr);
        for (int i = 0; i < n; i++) begin
            script_mode = script;
            req = script ? 3'($urandom_range(1, 7)) : 3'b000;
            clear_err = clr;
            step();
            if (clr) err_m = 1'b0;
            check_idle("idle");
        end
        clear_err = 1'b0;
    endtask

    task automatic reset_mid_send();
        req = 3'b010; script_mode = 1'b0; tx_done = 1'b0; clear_err = 1'b0;
        step();
        check("rst.grant", 32'(grant), 32'b010);
        for (int i = 0; i < 3; i++) step();
        reset = 1'b1;
        step();
        ptr_m = 1; err_m = 1'b0;
        check("rst.tx_bits", 32'(tx_bits), 32'd0);
        check_idle("rst");
        reset = 1'b0;
        step();
        check("rst.arm_grant", 32'(grant), 32'd0);
        check("rst.arm_done",  32'(done),  32'd0);
        step();
        check("rst.regrant", 32'(grant), 32'b010);
        req = 3'b000;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        ptr_m = 1;
        check_idle("rst2");
    endtask

    initial begin
        reset = 1'b1; script_mode = 1'b0; req = 3'b000; tx_done = 1'b0; clear_err = 1'b0;
        req_data_0 = 8'h00; req_data_1 = 8'h00; req_data_2 = 8'h00;
        ptr_m = 1; err_m = 1'b0;
        for (int i = 0; i < 3; i++) step();
        check("reset.tx_bits", 32'(tx_bits), 32'd0);
        check_idle("reset");
        reset = 1'b0;
        step();
        check_idle("arm");

        // Round-robin between 1 and 2 with fixed bytes
        do_xfer(3'b110, 8'h10, 8'h21, 8'h42, 5, 1'b0, 1'b0);
        do_xfer(3'b110, 8'h10, 8'h21, 8'h42, 5, 1'b0, 1'b0);
        do_xfer(3'b110, 8'h10, 8'h21, 8'h42, 5, 1'b0, 1'b0);
        // req[0] always wins
        for (int i = 0; i < 3; i++) do_xfer(3'b111, 8'h5a, 8'h21, 8'h42, 2, 1'b0, 1'b0);
        // Timeout, then clear
        do_xfer(3'b100, 8'h00, 8'h00, 8'h77, int'(TO), 1'b0, 1'b0);
        idle_cycles(1, 1'b0, 1'b1);
        // tx_done coinciding with the timeout cycle, plus tx_done noise in GAP
        do_xfer(3'b010, 8'h00, 8'h33, 8'h00, int'(TO) - 1, 1'b0, 1'b1);
        // script_mode raised during SEND of a grant to 2
        do_xfer(3'b100, 8'h00, 8'h00, 8'h99, 3, 1'b1, 1'b0);
        idle_cycles(4, 1'b1, 1'b0);
        do_xfer(3'b110, 8'h00, 8'h44, 8'h55, 0, 1'b0, 1'b0);
        // Reset in the middle of a transfer
        reset_mid_send();

        for (int it = 0; it < 60; it++) begin
            do_xfer(3'($urandom_range(1, 7)), 8'($urandom), 8'($urandom), 8'($urandom),
                    int'($urandom_range(0, TO + 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0 || script_mode)
                idle_cycles(int'($urandom_range(1, 3)), 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tx_scheduler.md
TX_SCHEDULER -- requirements
Module: tx_scheduler

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 2: idle cycles inserted after every transfer (range 1..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 4096: SEND-state cycles allowed before abort (range 2..65535).
REQ-003 SHALL have port clock  input  1  UART-rate clock (uart_clk_16 domain), the block's only clock.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port script_mode  input  1  high while ScriptMem loads a script; blocks new grants.
REQ-006 SHALL have port req  input  3  per-requester request; bit0 game state, bit1 target select, bit2 operate.
REQ-007 SHALL have ports req_data_0, req_data_1, req_data_2  input  8 each  byte offered by each requester.
REQ-008 SHALL have port tx_done  input  1  UART io_dataIn_ready; one-cycle pulse per byte sent.
REQ-009 SHALL have port tx_bits  output  8  byte driven to UART io_dataIn_bits.
REQ-010 SHALL have port tx_valid  output  1  high while tx_bits holds a scheduled byte.
REQ-011 SHALL have port grant  output  3  one-hot, one-cycle pulse: requester's byte latched.
REQ-012 SHALL have port done  output  3  one-hot, one-cycle pulse: requester's byte confirmed sent.
REQ-013 SHALL have port cur_src  output  2  index of the requester being served (0..2); 3 when idle.
REQ-014 SHALL have port busy  output  1  high in SEND or GAP.
REQ-015 SHALL have ports clear_err  input  1  and timeout_err  output  1  sticky abort flag and its clear.

Function
REQ-016 SHALL implement a three-state FSM: IDLE, SEND, GAP.
REQ-017 IDLE: SHALL evaluate req each cycle when script_mode=0; with no eligible request, SHALL remain in IDLE.
REQ-018 Arbitration: SHALL give req[0] absolute priority; between req[1] and req[2] SHALL use a round-robin pointer.
REQ-019 Pointer SHALL start at requester 1 and SHALL move to the other requester after each grant to 1 or 2; a grant to 0 SHALL leave it unchanged.
REQ-020 On a winning request in IDLE at cycle N, the block SHALL, at edge N+1: latch req_data_k into tx_bits, enter SEND, assert grant[k] for cycle N+1 only, set tx_valid=1 and cur_src=k.
REQ-021 tx_bits SHALL stay constant from grant until SEND exits; later changes on req_data SHALL have no effect.
REQ-022 SEND: SHALL count cycles from 0; on tx_done=1, the block SHALL pulse done[k] in the next cycle, drop tx_valid and enter GAP.
REQ-023 SEND: if the counter reaches TIMEOUT_CYCLES-1 without tx_done, the block SHALL set timeout_err, drop tx_valid, enter GAP, and issue no done pulse.
REQ-024 tx_done and timeout in the same cycle: tx_done SHALL win (done pulse, no error).
REQ-025 GAP: SHALL stay exactly GAP_CYCLES cycles, then return to IDLE with cur_src=3; req and tx_done SHALL be ignored.
REQ-026 tx_done in IDLE or GAP SHALL be ignored.
REQ-027 script_mode=1 SHALL suppress grants only in IDLE; an in-flight SEND/GAP SHALL complete normally.
REQ-028 A requester still asserting req after its grant SHALL be re-arbitrated on the next IDLE, so it can receive another transfer.
REQ-029 timeout_err SHALL clear on clear_err=1; if a timeout occurs in the same cycle as clear_err, set SHALL win.
REQ-030 Cycle counters SHALL be 16 bits and SHALL not wrap in SEND; the GAP counter SHALL be 8 bits.

Reset
REQ-031 reset=1 at any edge, including mid-SEND, SHALL force IDLE, tx_bits=0, tx_valid=0, grant=0, done=0, cur_src=3, busy=0, timeout_err=0, and pointer=1; an aborted transfer SHALL produce no done pulse.
REQ-032 The first grant SHALL be possible at the edge after the edge where reset is low.

Verification
REQ-033 req=3'b110, data1=8'h21, data2=8'h42 held, tx_done 5 cycles after each grant -> grants go to 1, then 2, then 1; tx_bits is 8'h21 then 8'h42; each done arrives 1 cycle after its tx_done.
REQ-034 req=3'b111 held -> every grant goes to 0; requesters 1 and 2 are never served while req[0] stays high.
REQ-035 Grant with no tx_done, TIMEOUT_CYCLES=16 -> tx_valid drops after 16 SEND cycles, timeout_err=1, done=0, and IDLE follows after GAP_CYCLES cycles; clear_err -> timeout_err=0.
REQ-036 script_mode=1 raised in the SEND cycle of a grant to 2 -> the transfer completes with done[2]; no further grant until script_mode=0.
REQ-037 reset pulsed 3 cycles into SEND -> all outputs take their reset values next cycle, no done pulse, and the next req[1] grant occurs 2 edges after reset falls.
REQ-038 tx_done and the timeout coincide, and tx_done is pulsed in GAP -> exactly one done pulse, timeout_err stays 0, and the GAP tx_done has no effect.
